dmem_arbiter: RTL and testbench

//  Shares the single-port data memory (WE/I/A/WD -> RD, registered read) between two requesters:

---
 rtl/dmem_arbiter_pkg.sv | 29 ++
 rtl/dmem_rr_pick.sv | 23 ++
 rtl/dmem_arbiter.sv | 127 ++++++++++++
 tb/tb_dmem_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: access size codes,
// FSM state encoding and the request legality check.
package dmem_arbiter_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DATA  = 2'd2
    } state_e;

    // Unsigned loads have no store counterpart.
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        bad = 1'b1;
        unique case (f3)
            F3_LB, F3_LH, F3_LW: bad = 1'b0;
            F3_LBU, F3_LHU:      bad = we;
            default:             bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/dmem_rr_pick.sv
// Two-way requester pick: round-robin against the last grant, or fixed
// priority to port 0 when RR is 0.
module dmem_rr_pick #(
    parameter int RR = 1
) (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (RR == 0) begin
            gnt[0] = req[0];
            gnt[1] = req[1] & ~req[0];
        end else if (req == 2'b11) begin
            gnt = last ? 2'b01 : 2'b10;
        end else begin
            gnt = req;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port registered-read data memory between the core LSU
// (port 0) and the loader/DMA (port 1), one access per three cycles.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int MEM_SIZE = 1024,
    parameter int RR       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        r0_valid,
    output logic        r0_ready,
    input  logic        r0_we,
    input  logic [2:0]  r0_funct3,
    input  logic [31:0] r0_addr,
    input  logic [31:0] r0_wdata,
    output logic        r0_rsp_valid,
    output logic [31:0] r0_rsp_rdata,
    output logic        r0_rsp_err,
    input  logic        r1_valid,
    output logic        r1_ready,
    input  logic        r1_we,
    input  logic [2:0]  r1_funct3,
    input  logic [31:0] r1_addr,
    input  logic [31:0] r1_wdata,
    output logic        r1_rsp_valid,
    output logic [31:0] r1_rsp_rdata,
    output logic        r1_rsp_err,
    output logic        mem_we,
    output logic [2:0]  mem_i,
    output logic [31:0] mem_a,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        owner_q, owner_d;
    logic        err_q, err_d;
    logic        last_q, last_d;

    logic [1:0]  gnt;
    logic        accept;
    logic        rsp_v;
    logic [31:0] rsp_data;

    dmem_rr_pick #(.RR(RR)) u_pick (
        .req  ({r1_valid, r0_valid}),
        .last (last_q),
        .gnt  (gnt)
    );

    assign accept   = (state_q == ST_IDLE) & ~rst;
    assign r0_ready = accept & gnt[0];
    assign r1_ready = accept & gnt[1];

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        owner_d = owner_q;
        err_d   = err_q;
        last_d  = last_q;
        unique case (state_q)
            ST_IDLE: begin
                if (r0_ready | r1_ready) begin
                    owner_d = r1_ready;
                    last_d  = r1_ready;
                    we_d    = r1_ready ? r1_we     : r0_we;
                    f3_d    = r1_ready ? r1_funct3 : r0_funct3;
                    addr_d  = r1_ready ? r1_addr   : r0_addr;
                    wdata_d = r1_ready ? r1_wdata  : r0_wdata;
                    err_d   = f3_illegal(we_d, f3_d)
                            | (addr_d >= 32'(MEM_SIZE));
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_DATA;
            ST_DATA:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            owner_q <= 1'b0;
            err_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            owner_q <= owner_d;
            err_q   <= err_d;
            last_q  <= last_d;
        end
    end

    // Write gated by rst directly so a reset landing in ISSUE never stores.
    assign mem_we = (state_q == ST_ISSUE) & we_q & ~err_q & ~rst;
    assign mem_i  = f3_q;
    assign mem_a  = addr_q;
    assign mem_wd = wdata_q;

    assign rsp_v    = (state_q == ST_DATA) & ~rst;
    assign rsp_data = (~we_q & ~err_q) ? mem_rd : 32'h0;

    assign r0_rsp_valid = rsp_v & ~owner_q;
    assign r1_rsp_valid = rsp_v & owner_q;
    assign r0_rsp_rdata = r0_rsp_valid ? rsp_data : 32'h0;
    assign r1_rsp_rdata = r1_rsp_valid ? rsp_data : 32'h0;
    assign r0_rsp_err   = r0_rsp_valid & err_q;
    assign r1_rsp_err   = r1_rsp_valid & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: a round-robin arbiter with a behavioural memory, plus a
// fixed-priority instance sharing the same requests.
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        r0_valid, r0_we, r1_valid, r1_we;
    logic [2:0]  r0_f3, r1_f3;
    logic [31:0] r0_addr, r0_wdata, r1_addr, r1_wdata;

    logic        a_r0_ready, a_r1_ready, a_r0_rsp_valid, a_r1_rsp_valid;
    logic        a_r0_rsp_err, a_r1_rsp_err, a_mem_we;
    logic [31:0] a_r0_rsp_rdata, a_r1_rsp_rdata, a_mem_a, a_mem_wd, a_mem_rd;
    logic [2:0]  a_mem_i;

    logic        b_r0_ready, b_r1_ready, b_r0_rsp_valid, b_r1_rsp_valid;
    logic        b_r0_rsp_err, b_r1_rsp_err, b_mem_we;
    logic [31:0] b_r0_rsp_rdata, b_r1_rsp_rdata, b_mem_a, b_mem_wd;
    logic [31:0] b_mem_rd = 32'h0;
    logic [2:0]  b_mem_i;

    logic        pl_en = 1'b0;
    logic [9:0]  pl_addr = 10'd0;
    logic [31:0] pl_data = 32'h0;
    logic [31:0] mem [0:1023];
    int          we_cnt = 0;
    int          passed = 0;
    int          total = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.MEM_SIZE(1024), .RR(1)) u_rr (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(a_r0_ready), .r0_we(r0_we),
        .r0_funct3(r0_f3), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_rsp_valid(a_r0_rsp_valid), .r0_rsp_rdata(a_r0_rsp_rdata),
        .r0_rsp_err(a_r0_rsp_err),
        .r1_valid(r1_valid), .r1_ready(a_r1_ready), .r1_we(r1_we),
        .r1_funct3(r1_f3), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_rsp_valid(a_r1_rsp_valid), .r1_rsp_rdata(a_r1_rsp_rdata),
        .r1_rsp_err(a_r1_rsp_err),
        .mem_we(a_mem_we), .mem_i(a_mem_i), .mem_a(a_mem_a),
        .mem_wd(a_mem_wd), .mem_rd(a_mem_rd)
    );

    dmem_arbiter #(.MEM_SIZE(1024), .RR(0)) u_fp (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(b_r0_ready), .r0_we(r0_we),
        .r0_funct3(r0_f3), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_rsp_valid(b_r0_rsp_valid), .r0_rsp_rdata(b_r0_rsp_rdata),
        .r0_rsp_err(b_r0_rsp_err),
        .r1_valid(r1_valid), .r1_ready(b_r1_ready), .r1_we(r1_we),
        .r1_funct3(r1_f3), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_rsp_valid(b_r1_rsp_valid), .r1_rsp_rdata(b_r1_rsp_rdata),
        .r1_rsp_err(b_r1_rsp_err),
        .mem_we(b_mem_we), .mem_i(b_mem_i), .mem_a(b_mem_a),
        .mem_wd(b_mem_wd), .mem_rd(b_mem_rd)
    );

    function automatic logic [31:0] ext(input logic [31:0] w, input logic [2:0] i);
        case (i)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'h0, w[7:0]};
            3'b101:  return {16'h0, w[15:0]};
            default: return w;
        endcase
    endfunction

    always @(posedge clk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (a_mem_we) begin
            case (a_mem_i[1:0])
                2'b00:   mem[a_mem_a[9:0]][7:0]  <= a_mem_wd[7:0];
                2'b01:   mem[a_mem_a[9:0]][15:0] <= a_mem_wd[15:0];
                default: mem[a_mem_a[9:0]]       <= a_mem_wd;
            endcase
        end
        a_mem_rd <= ext(mem[a_mem_a[9:0]], a_mem_i);
    end

    always @(posedge clk) begin
        if (a_mem_we) we_cnt <= we_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic setreq(input bit p, input logic v, input logic we,
                          input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd);
        if (p) begin
            r1_valid = v; r1_we = we; r1_f3 = f3; r1_addr = a; r1_wdata = wd;
        end else begin
            r0_valid = v; r0_we = we; r0_f3 = f3; r0_addr = a; r0_wdata = wd;
        end
    endtask

    task automatic preload(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    task automatic access(input bit p, input logic we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input string tag,
                          output logic [31:0] rd, output logic er);
        @(negedge clk);
        setreq(p, 1'b1, we, f3, a, wd);
        #1 chk({tag, ".ready"}, p ? a_r1_ready : a_r0_ready, 32'd1);
        @(negedge clk);
        setreq(p, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        chk({tag, ".mem_a"}, a_mem_a, a);
        @(negedge clk);
        chk({tag, ".rspv"}, p ? a_r1_rsp_valid : a_r0_rsp_valid, 32'd1);
        chk({tag, ".other_rspv"}, p ? a_r0_rsp_valid : a_r1_rsp_valid, 32'd0);
        rd = p ? a_r1_rsp_rdata : a_r0_rsp_rdata;
        er = p ? a_r1_rsp_err : a_r0_rsp_err;
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          w0;

        rst = 1'b1;
        setreq(0, 1'b1, 1'b0, F3_LW, 32'd5, 32'h0);
        setreq(1, 1'b0, 1'b0, F3_LW, 32'd0, 32'h0);
        for (int i = 0; i < 1024; i++) preload(10'(i), 32'h0);
        preload(10'd5, 32'hCAFEBABE);
        preload(10'd3, 32'h11223344);
        preload(10'd7, 32'h01020304);
        preload(10'd9, 32'h99887766);
        #1 chk("rst.r0_ready", a_r0_ready, 32'd0);
        setreq(0, 1'b0, 1'b0, F3_LW, 32'd0, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("idle.r0_ready", a_r0_ready, 32'd0);
        chk("idle.r1_ready", a_r1_ready, 32'd0);
        chk("idle.rspv", {a_r0_rsp_valid, a_r1_rsp_valid}, 32'd0);
        chk("idle.rdata", a_r0_rsp_rdata | a_r1_rsp_rdata, 32'd0);
        chk("idle.err", {a_r0_rsp_err, a_r1_rsp_err}, 32'd0);
        chk("idle.mem_we", a_mem_we, 32'd0);
        chk("idle.mem_i", a_mem_i, 32'd0);
        chk("idle.mem_a", a_mem_a, 32'd0);
        chk("idle.mem_wd", a_mem_wd, 32'd0);

        access(0, 1'b0, F3_LW, 32'd5, 32'h0, "lw5", rd, er);
        chk("lw5.rdata", rd, 32'hCAFEBABE);
        chk("lw5.err", er, 32'd0);

        access(1, 1'b1, F3_LB, 32'd3, 32'hAABBCCDD, "sb3", rd, er);
        chk("sb3.rdata", rd, 32'h0);
        chk("sb3.err", er, 32'd0);
        access(1, 1'b0, F3_LB, 32'd3, 32'h0, "lb3", rd, er);
        chk("lb3.rdata", rd, 32'hFFFFFFDD);
        access(1, 1'b0, F3_LBU, 32'd3, 32'h0, "lbu3", rd, er);
        chk("lbu3.rdata", rd, 32'h000000DD);
        access(1, 1'b0, F3_LW, 32'd3, 32'h0, "lw3", rd, er);
        chk("lw3.rdata", rd, 32'h112233DD);

        w0 = we_cnt;
        access(0, 1'b1, 3'b110, 32'd9, 32'hDEADBEEF, "badf3", rd, er);
        chk("badf3.err", er, 32'd1);
        chk("badf3.rdata", rd, 32'h0);
        chk("badf3.no_we", 32'(we_cnt - w0), 32'd0);
        access(0, 1'b0, F3_LW, 32'd9, 32'h0, "lw9", rd, er);
        chk("lw9.rdata", rd, 32'h99887766);
        access(0, 1'b0, F3_LW, 32'd1024, 32'h0, "oob", rd, er);
        chk("oob.err", er, 32'd1);
        chk("oob.rdata", rd, 32'h0);
        access(0, 1'b1, F3_LBU, 32'd9, 32'h0, "sbu", rd, er);
        chk("sbu.err", er, 32'd1);
        chk("sbu.no_we", 32'(we_cnt - w0), 32'd0);

        @(negedge clk);
        setreq(0, 1'b1, 1'b1, F3_LW, 32'd7, 32'h5A5A5A5A);
        #1 chk("rstis.ready", a_r0_ready, 32'd1);
        @(negedge clk);
        setreq(0, 1'b0, 1'b0, F3_LW, 32'd0, 32'h0);
        rst = 1'b1;
        w0 = we_cnt;
        #1 chk("rstis.mem_we", a_mem_we, 32'd0);
        @(negedge clk);
        chk("rstis.rspv", {a_r0_rsp_valid, a_r1_rsp_valid}, 32'd0);
        chk("rstis.mem_a", a_mem_a, 32'd0);
        chk("rstis.mem_wd", a_mem_wd, 32'd0);
        chk("rstis.no_we", 32'(we_cnt - w0), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rstis.after_rspv", {a_r0_rsp_valid, a_r1_rsp_valid}, 32'd0);
        access(0, 1'b0, F3_LW, 32'd7, 32'h0, "lw7", rd, er);
        chk("lw7.rdata", rd, 32'h01020304);

        @(negedge clk);
        setreq(0, 1'b1, 1'b0, F3_LW, 32'd5, 32'h0);
        #1 chk("b2b.ready0", a_r0_ready, 32'd1);
        @(negedge clk);
        chk("b2b.issue_ready", a_r0_ready, 32'd0);
        @(negedge clk);
        chk("b2b.data_ready", a_r0_ready, 32'd0);
        chk("b2b.rspv", a_r0_rsp_valid, 32'd1);
        chk("b2b.rdata", a_r0_rsp_rdata, 32'hCAFEBABE);
        @(negedge clk);
        chk("b2b.ready1", a_r0_ready, 32'd1);
        setreq(0, 1'b0, 1'b0, F3_LW, 32'd0, 32'h0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        setreq(0, 1'b1, 1'b0, F3_LW, 32'd5, 32'h0);
        setreq(1, 1'b1, 1'b0, F3_LW, 32'd3, 32'h0);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr%0d.g0", k), a_r0_ready, 32'((k % 2) == 0));
            chk($sformatf("rr%0d.g1", k), a_r1_ready, 32'((k % 2) == 1));
            chk($sformatf("fp%0d.g0", k), b_r0_ready, 32'd1);
            chk($sformatf("fp%0d.g1", k), b_r1_ready, 32'd0);
            repeat (3) @(negedge clk);
            #1;
        end
        setreq(0, 1'b0, 1'b0, F3_LW, 32'd0, 32'h0);
        setreq(1, 1'b0, 1'b0, F3_LW, 32'd0, 32'h0);
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
